// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the dual-port SRAM arbiter.
package sram_arb_pkg;

  localparam int unsigned IdxW = 5;
  // Sentinel owner for a port that carries no read this cycle.
  localparam logic [IdxW-1:0] NO_OWNER = 5'h1f;

  typedef enum logic [0:0] {StInit, StRun} arb_state_e;

  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

  function automatic logic [IdxW-1:0] to_idx(input int unsigned i);
    return IdxW'(i);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first requester at or after rr_i that is valid and not masked.
module rr_pick
  import sram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [NUM_REQ-1:0] mask_i,
  input  logic [IdxW-1:0]    rr_i,
  output logic [IdxW-1:0]    idx_o,
  output logic               found_o
);

  logic [31:0]   elig;
  logic [IdxW:0] cand;

  always_comb begin
    elig    = 32'(valid_i & ~mask_i);
    found_o = 1'b0;
    idx_o   = NO_OWNER;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_i} + (IdxW+1)'(k);
      if (cand >= (IdxW+1)'(NUM_REQ)) begin
        cand = cand - (IdxW+1)'(NUM_REQ);
      end
      if (!found_o && elig[cand[IdxW-1:0]]) begin
        found_o = 1'b1;
        idx_o   = cand[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Grants up to two non-conflicting requests per cycle onto a dual-port SRAM, round-robin.
// Optional post-reset init sweep is compiled in with SRAM_ARB_INIT_SWEEP_EN.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned      WIDTH    = 8,
  parameter int unsigned      DEPTH    = 64,
  parameter int unsigned      LG_DEPTH = 6,
  parameter int unsigned      NUM_REQ  = 4,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*LG_DEPTH-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]    req_din,
  output logic [NUM_REQ-1:0]          resp_valid,
  output logic [NUM_REQ*WIDTH-1:0]    resp_dout,
  output logic                        init_done,
  output logic [LG_DEPTH-1:0]         sram_addr_0,
  output logic [LG_DEPTH-1:0]         sram_addr_1,
  output logic [WIDTH-1:0]            sram_din_0,
  output logic [WIDTH-1:0]            sram_din_1,
  output logic                        sram_we_0,
  output logic                        sram_we_1,
  input  logic [WIDTH-1:0]            sram_dout_0,
  input  logic [WIDTH-1:0]            sram_dout_1
);

  if ((DEPTH % 2) != 0 || DEPTH != (32'd1 << LG_DEPTH)) begin : gen_bad_cfg
    $error("sram_port_arbiter: DEPTH must be even and equal 2**LG_DEPTH");
  end

`ifdef SRAM_ARB_INIT_SWEEP_EN
  localparam arb_state_e ResetState = StInit;
  logic [LG_DEPTH-1:0] cnt_q, cnt_d;
`else
  localparam arb_state_e ResetState = StRun;
`endif

  arb_state_e               state_q, state_d;
  logic                     run_q, run_d;
  logic [IdxW-1:0]          rr_q, rr_d;
  logic [IdxW-1:0]          own0_q, own0_d, own1_q, own1_d;
  logic                     rd0_q, rd0_d, rd1_q, rd1_d;
  logic [NUM_REQ*WIDTH-1:0] dout_q, dout_d;

  logic                     active, g0, g1;
  logic                     p0_found, p1_found;
  logic [IdxW-1:0]          p0_idx, p1_idx, last_idx;
  logic [NUM_REQ-1:0]       mask1;
  logic [LG_DEPTH-1:0]      p0_addr, p1_addr;
  logic [WIDTH-1:0]         p0_din, p1_din;
  logic                     p0_we, p1_we;

  assign active    = run_q && (state_q == StRun);
  assign init_done = active;
  assign g0        = active && p0_found;
  assign g1        = active && p1_found;

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick0 (
    .valid_i(req_valid),
    .mask_i ({NUM_REQ{1'b0}}),
    .rr_i   (rr_q),
    .idx_o  (p0_idx),
    .found_o(p0_found)
  );

  // Port 1 excludes the port-0 winner and anything colliding with its access.
  always_comb begin
    p0_addr = '0;
    p0_din  = '0;
    p0_we   = 1'b0;
    mask1   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (p0_found && p0_idx == to_idx(i)) begin
        p0_addr  = req_addr[slice_lo(i, LG_DEPTH) +: LG_DEPTH];
        p0_din   = req_din[slice_lo(i, WIDTH) +: WIDTH];
        p0_we    = req_we[i];
        mask1[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (p0_found && req_addr[slice_lo(i, LG_DEPTH) +: LG_DEPTH] == p0_addr &&
          (req_we[i] || p0_we)) begin
        mask1[i] = 1'b1;
      end
    end
  end

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick1 (
    .valid_i(req_valid),
    .mask_i (mask1),
    .rr_i   (rr_q),
    .idx_o  (p1_idx),
    .found_o(p1_found)
  );

  always_comb begin
    p1_addr   = '0;
    p1_din    = '0;
    p1_we     = 1'b0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (p1_found && p1_idx == to_idx(i)) begin
        p1_addr = req_addr[slice_lo(i, LG_DEPTH) +: LG_DEPTH];
        p1_din  = req_din[slice_lo(i, WIDTH) +: WIDTH];
        p1_we   = req_we[i];
      end
      req_ready[i] = (g0 && p0_idx == to_idx(i)) || (g1 && p1_idx == to_idx(i));
    end
  end

  always_comb begin
    sram_addr_0 = '0;
    sram_addr_1 = '0;
    sram_din_0  = '0;
    sram_din_1  = '0;
    sram_we_0   = 1'b0;
    sram_we_1   = 1'b0;
`ifdef SRAM_ARB_INIT_SWEEP_EN
    if (run_q && state_q == StInit) begin
      sram_addr_0 = cnt_q;
      sram_addr_1 = cnt_q + LG_DEPTH'(1);
      sram_din_0  = INIT_VAL;
      sram_din_1  = INIT_VAL;
      sram_we_0   = 1'b1;
      sram_we_1   = 1'b1;
    end
`endif
    if (g0) begin
      sram_addr_0 = p0_addr;
      sram_din_0  = p0_din;
      sram_we_0   = p0_we;
    end
    if (g1) begin
      sram_addr_1 = p1_addr;
      sram_din_1  = p1_din;
      sram_we_1   = p1_we;
    end
  end

  always_comb begin
    run_d    = 1'b1;
    state_d  = state_q;
    rr_d     = rr_q;
    last_idx = g1 ? p1_idx : p0_idx;
`ifdef SRAM_ARB_INIT_SWEEP_EN
    cnt_d = cnt_q;
    if (run_q && state_q == StInit) begin
      cnt_d = cnt_q + LG_DEPTH'(2);
      if (cnt_q == LG_DEPTH'(DEPTH - 2)) begin
        state_d = StRun;
      end
    end
`endif
    if (g0) begin
      rr_d = (last_idx == to_idx(NUM_REQ - 1)) ? '0 : last_idx + IdxW'(1);
    end
    rd0_d  = g0 && !p0_we;
    rd1_d  = g1 && !p1_we;
    own0_d = rd0_d ? p0_idx : NO_OWNER;
    own1_d = rd1_d ? p1_idx : NO_OWNER;
  end

  // Read data arrives from the SRAM one cycle after the grant; undriven slices hold.
  always_comb begin
    resp_valid = '0;
    resp_dout  = dout_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rd0_q && own0_q == to_idx(i)) begin
        resp_valid[i]                        = 1'b1;
        resp_dout[slice_lo(i, WIDTH) +: WIDTH] = sram_dout_0;
      end
      if (rd1_q && own1_q == to_idx(i)) begin
        resp_valid[i]                        = 1'b1;
        resp_dout[slice_lo(i, WIDTH) +: WIDTH] = sram_dout_1;
      end
    end
  end

  assign dout_d = resp_dout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ResetState;
      run_q   <= 1'b0;
      rr_q    <= '0;
      own0_q  <= NO_OWNER;
      own1_q  <= NO_OWNER;
      rd0_q   <= 1'b0;
      rd1_q   <= 1'b0;
      dout_q  <= '0;
`ifdef SRAM_ARB_INIT_SWEEP_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      rr_q    <= rr_d;
      own0_q  <= own0_d;
      own1_q  <= own1_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      dout_q  <= dout_d;
`ifdef SRAM_ARB_INIT_SWEEP_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule
